stim_gen: RTL

STIM_GEN -- requirements
Module: stim_gen

---
 rtl/stim_pkg.sv | 72 +++++++
 rtl/stim_gen_lfsr32.sv | 34 +++
 rtl/stim_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus generator.
//   - stimulus mode and FSM state encodings
//   - Galois LFSR tap constant and the mask that derives the B seed
//   - corner-value table and the LFSR helper functions
package stim_pkg;

  typedef enum logic [1:0] {
    MODE_RANDOM = 2'd0,
    MODE_CORNER = 2'd1,
    MODE_WALK   = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam logic [31:0] B_SEED_MASK = 32'hA5A5_A5A5;
  localparam logic [31:0] LFSR_ONE    = 32'h0000_0001;

  // One right-shifting Galois step; the taps are folded in when bit 0 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) begin
      r = r ^ LFSR_TAPS;
    end else begin
      r = r;
    end
    return r;
  endfunction

  // An all-zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    logic [31:0] r;
    if (s == 32'd0) begin
      r = LFSR_ONE;
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Corner-value table, indexed by a 4-bit slice of the test index.
  function automatic logic [31:0] corner_value(input logic [3:0] idx);
    logic [31:0] r;
    case (idx)
      4'd0:    r = 32'h0000_0000;
      4'd1:    r = 32'h0000_0001;
      4'd2:    r = 32'h0000_0002;
      4'd3:    r = 32'h0000_0003;
      4'd4:    r = 32'h7FFF_FFFE;
      4'd5:    r = 32'h7FFF_FFFF;
      4'd6:    r = 32'h8000_0000;
      4'd7:    r = 32'h8000_0001;
      4'd8:    r = 32'hFFFF_FFFE;
      4'd9:    r = 32'hFFFF_FFFF;
      4'd10:   r = 32'h5555_5555;
      4'd11:   r = 32'hAAAA_AAAA;
      4'd12:   r = 32'h0000_FFFF;
      4'd13:   r = 32'hFFFF_0000;
      4'd14:   r = 32'h4000_0000;
      4'd15:   r = 32'hC000_0000;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stim_gen_lfsr32.sv
// 32-bit Galois LFSR used as a random operand source.
// Ports:
//   clk, reset : clock and synchronous active-high reset (state -> 1)
//   load       : replace the state with seed (zero seed becomes 1)
//   advance    : step the LFSR once; with load, the step is taken from the seed
//   seed       : seed value used on load
//   state      : current LFSR state
module lfsr32
  import stim_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  logic [31:0] state_r;

  // State register: load (optionally with one step) or free advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LFSR_ONE;
    end else if (load) begin
      state_r <= advance ? lfsr_step(seed_fix(seed)) : seed_fix(seed);
    end else if (advance) begin
      state_r <= lfsr_step(state_r);
    end
  end

  assign state = state_r;

endmodule

// File: rtl/stim_gen.sv
// Operand-pair stimulus generator.
// A run of i_num_tests pairs is started by i_start in IDLE; one pair is
// issued per cycle, the first one the cycle after i_start.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   i_start                 : run request, sampled only in IDLE
//   i_num_tests/i_mode/i_seed : run parameters, sampled with i_start
//   o_dut_ia, o_dut_ib      : registered operand pair (held when idle)
//   o_valid                 : a new pair is present this cycle
//   o_busy                  : run in progress
//   o_done                  : one-cycle end-of-run pulse
module stim_gen
  import stim_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [31:0]      i_num_tests,
  input  logic [1:0]       i_mode,
  input  logic [31:0]      i_seed,
  output logic [WIDTH-1:0] o_dut_ia,
  output logic [WIDTH-1:0] o_dut_ib,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done
);

  state_e      state_r, state_n;
  mode_e       mode_r, issue_mode_s;
  logic [31:0] cnt_r, k_r, k_n, issue_k_s;
  logic        issue_s, done_s, latch_s, lfsr_load_s, lfsr_adv_s;
  logic [31:0] a_state_s, b_state_s, a_pair_s, b_pair_s;
  logic [WIDTH-1:0] ia_r, ib_r;
  logic        valid_r, busy_r, done_r;

  lfsr32 u_lfsr_a (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load_s),
    .advance (lfsr_adv_s),
    .seed    (i_seed),
    .state   (a_state_s)
  );

  lfsr32 u_lfsr_b (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load_s),
    .advance (lfsr_adv_s),
    .seed    (i_seed ^ B_SEED_MASK),
    .state   (b_state_s)
  );

  // Next-state logic and selection of which pair index to issue next.
  always_comb begin
    state_n      = state_r;
    k_n          = k_r;
    issue_s      = 1'b0;
    done_s       = 1'b0;
    latch_s      = 1'b0;
    lfsr_load_s  = 1'b0;
    lfsr_adv_s   = 1'b0;
    issue_k_s    = k_r;
    issue_mode_s = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          if (i_num_tests != 32'd0) begin
            state_n      = ST_RUN;
            latch_s      = 1'b1;
            k_n          = 32'd0;
            issue_s      = 1'b1;
            issue_k_s    = 32'd0;
            issue_mode_s = mode_e'(i_mode);
            // Load and step together so the LFSR always holds the pair on display.
            lfsr_load_s  = 1'b1;
            lfsr_adv_s   = 1'b1;
          end else begin
            state_n = ST_DONE;
            done_s  = 1'b1;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        // k_r is the index currently on the outputs.
        if (k_r == cnt_r - 32'd1) begin
          state_n = ST_DONE;
          done_s  = 1'b1;
        end else begin
          k_n        = k_r + 32'd1;
          issue_s    = 1'b1;
          issue_k_s  = k_r + 32'd1;
          lfsr_adv_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Operand pair for the index being issued, per stimulus mode.
  always_comb begin
    a_pair_s = 32'd0;
    b_pair_s = 32'd0;
    case (issue_mode_s)
      MODE_RANDOM: begin
        if (lfsr_load_s) begin
          a_pair_s = lfsr_step(seed_fix(i_seed));
          b_pair_s = lfsr_step(seed_fix(i_seed ^ B_SEED_MASK));
        end else begin
          a_pair_s = lfsr_step(a_state_s);
          b_pair_s = lfsr_step(b_state_s);
        end
      end
      MODE_CORNER: begin
        a_pair_s = corner_value(issue_k_s[7:4]);
        b_pair_s = corner_value(issue_k_s[3:0]);
      end
      MODE_WALK: begin
        a_pair_s = 32'd1 << issue_k_s[4:0];
        b_pair_s = ~(32'd1 << issue_k_s[4:0]);
      end
      MODE_COUNT: begin
        a_pair_s = issue_k_s;
        b_pair_s = ~issue_k_s;
      end
      default: begin
        a_pair_s = 32'd0;
        b_pair_s = 32'd0;
      end
    endcase
  end

  // State, run parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_RANDOM;
      cnt_r   <= 32'd0;
      k_r     <= 32'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ia_r    <= '0;
      ib_r    <= '0;
    end else begin
      state_r <= state_n;
      k_r     <= k_n;
      valid_r <= issue_s;
      busy_r  <= issue_s;
      done_r  <= done_s;
      if (latch_s) begin
        mode_r <= mode_e'(i_mode);
        cnt_r  <= i_num_tests;
      end
      if (issue_s) begin
        ia_r <= a_pair_s;
        ib_r <= b_pair_s;
      end
    end
  end

  assign o_dut_ia = ia_r;
  assign o_dut_ib = ib_r;
  assign o_valid  = valid_r;
  assign o_busy   = busy_r;
  assign o_done   = done_r;

endmodule
